balance_seq: RTL and testbench

- Top-level sequencer for the self-balancing control loop.
- Qualifies the rider from the two load-cell readings and gates the inertial vld strobe to the PID block.
- Drives the PID's pwr_up and rider_off inputs and watches the PID's ss_tmr to end soft-start.
- Enables the motor drivers and latches tilt and sensor-timeout faults.

---
 rtl/balance_seq.sv | 148 ++++++++++++++
 tb/tb_balance_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/balance_seq.sv
// Top-level sequencer for the self-balancing loop: rider qualification, soft-start
// handshake with the PID, motor enable, and latched tilt / sensor-timeout faults.
module balance_seq #(
    parameter bit                 fast_sim     = 1'b1,
    parameter logic [12:0]        MIN_RIDER_WT = 13'h0200,
    parameter logic [12:0]        WT_HYST      = 13'h0040,
    parameter logic signed [15:0] TILT_LIM     = 16'sd4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [11:0]        lft_ld,
    input  logic [11:0]        rght_ld,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic [7:0]         ss_tmr,
    output logic               vld_pid,
    output logic               pwr_up,
    output logic               rider_off,
    output logic               mtr_en,
    output logic               fault,
    output logic [2:0]         state
);

    localparam int DEB_CYC = fast_sim ? 16 : 1_048_576;
    localparam int VLD_TMO = fast_sim ? 256 : 65_535;
    localparam int DEB_W   = $clog2(DEB_CYC);
    localparam int WD_W    = $clog2(VLD_TMO + 1);

    localparam logic [12:0]        OFF_WT   = MIN_RIDER_WT - WT_HYST;
    localparam logic signed [15:0] TILT_NEG = -TILT_LIM;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_RIDER = 3'd1,
        SOFT_START = 3'd2,
        BALANCE    = 3'd3,
        FAULT      = 3'd4
    } state_t;

    state_t            cur_st, nxt_st;
    logic              rider_flag;
    logic [DEB_W-1:0]  deb_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [12:0]       ld_sum;
    logic              active, deb_run, deb_tgt, deb_done, tilt_flt, wd_tmo;
    logic              pwr_up_d, rider_off_d, mtr_en_d, fault_d;

    assign ld_sum   = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign active   = (cur_st == SOFT_START) || (cur_st == BALANCE);
    assign deb_run  = active || (cur_st == WAIT_RIDER);
    assign deb_tgt  = (cur_st == WAIT_RIDER);
    assign deb_done = deb_run && (rider_flag == deb_tgt) && (deb_cnt == DEB_W'(DEB_CYC - 1));
    assign tilt_flt = vld && ((ptch > TILT_LIM) || (ptch < TILT_NEG));
    // A vld landing on the saturation cycle rescues the loop.
    assign wd_tmo   = (wd_cnt == WD_W'(VLD_TMO)) && !vld;
    assign vld_pid  = vld && active;
    assign state    = cur_st;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        nxt_st = cur_st;
        if (!en) begin
            nxt_st = IDLE;
        end else begin
            case (cur_st)
                IDLE:       nxt_st = WAIT_RIDER;
                WAIT_RIDER: if (deb_done) nxt_st = SOFT_START;
                SOFT_START: begin
                    if (tilt_flt || wd_tmo)   nxt_st = FAULT;
                    else if (ss_tmr == 8'hFF) nxt_st = BALANCE;
                    else if (deb_done)        nxt_st = WAIT_RIDER;
                end
                BALANCE: begin
                    if (tilt_flt || wd_tmo) nxt_st = FAULT;
                    else if (deb_done)      nxt_st = WAIT_RIDER;
                end
                FAULT:      nxt_st = FAULT;
                default:    nxt_st = IDLE;
            endcase
        end
    end

    always_comb begin
        pwr_up_d    = 1'b0;
        rider_off_d = 1'b1;
        mtr_en_d    = 1'b0;
        fault_d     = 1'b0;
        case (nxt_st)
            SOFT_START, BALANCE: begin
                pwr_up_d    = 1'b1;
                rider_off_d = 1'b0;
                mtr_en_d    = 1'b1;
            end
            FAULT:   fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cur_st    <= IDLE;
            pwr_up    <= 1'b0;
            rider_off <= 1'b1;
            mtr_en    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            cur_st    <= nxt_st;
            pwr_up    <= pwr_up_d;
            rider_off <= rider_off_d;
            mtr_en    <= mtr_en_d;
            fault     <= fault_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rider_flag <= 1'b0;
        end else if (ld_sum > MIN_RIDER_WT) begin
            rider_flag <= 1'b1;
        end else if (ld_sum < OFF_WT) begin
            rider_flag <= 1'b0;
        end
    end

    // The debounce restarts whenever the state moves so each decision sees a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
        end else if ((nxt_st != cur_st) || !deb_run || (rider_flag != deb_tgt)) begin
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (!active || vld || ((nxt_st == SOFT_START) && (cur_st != SOFT_START))) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_W'(VLD_TMO)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

endmodule

// File: tb/tb_balance_seq.sv
// Directed bench for balance_seq: rider debounce, soft-start, tilt and watchdog
// faults, rider-off, and en/reset overrides, using the fast_sim constants.
module tb_balance_seq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [11:0]        lft_ld, rght_ld;
    logic               vld;
    logic signed [15:0] ptch;
    logic [7:0]         ss_tmr;
    logic               vld_pid, pwr_up, rider_off, mtr_en, fault;
    logic [2:0]         state;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_SS = 3'd2, S_BAL = 3'd3, S_FLT = 3'd4;

    balance_seq #(.fast_sim(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .vld(vld), .ptch(ptch), .ss_tmr(ss_tmr), .vld_pid(vld_pid), .pwr_up(pwr_up),
        .rider_off(rider_off), .mtr_en(mtr_en), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic pu,
                              input logic ro, input logic me, input logic fl);
        check({tag, ".state"},     16'(state),     16'(st));
        check({tag, ".pwr_up"},    16'(pwr_up),    16'(pu));
        check({tag, ".rider_off"}, 16'(rider_off), 16'(ro));
        check({tag, ".mtr_en"},    16'(mtr_en),    16'(me));
        check({tag, ".fault"},     16'(fault),     16'(fl));
    endtask

    task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    initial begin
        #200_000;
        $display("FAIL tb_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; vld = 1'b1; ptch = '0; ss_tmr = '0;
        set_ld(12'h000, 12'h000);
        step(2);
        check_outs("reset", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset.vld_pid", 16'(vld_pid), 16'd0);
        vld = 1'b0;
        rst_n = 1'b1;

        // Toggling load never qualifies (at most ~10 consecutive rider cycles).
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ld(12'h180, 12'h180);
            step(10);
            check("toggle_hi", 16'(state), 16'(S_WAIT));
            set_ld(12'h080, 12'h080);
            step(10);
            check("toggle_lo", 16'(state), 16'(S_WAIT));
        end

        // Steady sum 0x300: flag sets on first edge, then 16 qualifying cycles.
        set_ld(12'h180, 12'h180);
        step(16);
        check_outs("deb_15", S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        check_outs("soft_start", S_SS, 1'b1, 1'b0, 1'b1, 1'b0);
        vld = 1'b1; ptch = 16'sd100;
        #1 check("ss.vld_pid", 16'(vld_pid), 16'd1);
        step(1);
        vld = 1'b0;
        ss_tmr = 8'hFF;
        step(1);
        check_outs("balance", S_BAL, 1'b1, 1'b0, 1'b1, 1'b0);
        ss_tmr = 8'h00;

        // Sum 0x1D0 sits in the hysteresis band: rider stays on.
        set_ld(12'h0E8, 12'h0E8);
        step(40);
        check("hyst_hold", 16'(state), 16'(S_BAL));

        // Tilt exactly at the limit on both sides is allowed; 4097 faults.
        vld = 1'b1; ptch = -16'sd4096;
        step(1);
        check("tilt_neg_lim", 16'(state), 16'(S_BAL));
        ptch = 16'sd4096;
        step(1);
        check("tilt_pos_lim", 16'(state), 16'(S_BAL));
        ptch = 16'sd4097;
        step(1);
        check_outs("tilt_fault", S_FLT, 1'b0, 1'b1, 1'b0, 1'b1);
        vld = 1'b0; ptch = '0;
        step(5);
        check_outs("fault_sticky", S_FLT, 1'b0, 1'b1, 1'b0, 1'b1);
        en = 1'b0;
        step(1);
        check_outs("fault_clr", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back to balance, then the watchdog boundary.
        en = 1'b1;
        step(17);
        check("wd.ss", 16'(state), 16'(S_SS));
        ss_tmr = 8'hFF;
        step(1);
        ss_tmr = 8'h00;
        check("wd.bal", 16'(state), 16'(S_BAL));
        vld = 1'b1;
        step(1);
        vld = 1'b0;
        step(256);
        check("wd_256_quiet", 16'(state), 16'(S_BAL));
        vld = 1'b1;
        step(1);
        vld = 1'b0;
        check("wd_rescue", 16'(state), 16'(S_BAL));
        step(256);
        check("wd_refill", 16'(state), 16'(S_BAL));
        step(1);
        check_outs("wd_timeout", S_FLT, 1'b0, 1'b1, 1'b0, 1'b1);

        // Rider steps off in balance.
        en = 1'b0;
        step(1);
        en = 1'b1;
        step(17);
        ss_tmr = 8'hFF;
        step(1);
        ss_tmr = 8'h00;
        check("off.bal", 16'(state), 16'(S_BAL));
        set_ld(12'h080, 12'h080);
        step(16);
        check("off_15", 16'(state), 16'(S_BAL));
        step(1);
        check_outs("rider_off", S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0);
        vld = 1'b1;
        #1 check("wait.vld_pid", 16'(vld_pid), 16'd0);
        vld = 1'b0;

        // en=0 beats a tilt fault in soft-start.
        set_ld(12'h180, 12'h180);
        step(17);
        check("en_tilt.ss", 16'(state), 16'(S_SS));
        vld = 1'b1; ptch = -16'sd5000; en = 1'b0;
        step(1);
        check_outs("en_beats_tilt", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
        vld = 1'b0; ptch = '0; en = 1'b1;

        // Tilt and ss_tmr==FF together: fault wins.
        step(17);
        check("tilt_ff.ss", 16'(state), 16'(S_SS));
        vld = 1'b1; ptch = 16'sd5000; ss_tmr = 8'hFF;
        step(1);
        check_outs("tilt_beats_ff", S_FLT, 1'b0, 1'b1, 1'b0, 1'b1);
        vld = 1'b0; ptch = '0; ss_tmr = 8'h00;

        // Asynchronous reset in the middle of balance.
        en = 1'b0;
        step(1);
        en = 1'b1;
        step(17);
        ss_tmr = 8'hFF;
        step(1);
        ss_tmr = 8'h00;
        check_outs("pre_rst", S_BAL, 1'b1, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
